// File: rtl/sub16_serial_if.sv
// Handshake and operand/result bundle for the nibble-serial subtractor.
// The requester uses the master modport and the subtractor uses slave.
interface sub16_serial_if;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Bin;
    logic        busy;
    logic        done;
    logic [15:0] Diff;
    logic        Bout;
    logic        Zero;
    logic        Ovf;

    modport master (output start, A, B, Bin,
                    input  busy, done, Diff, Bout, Zero, Ovf);
    modport slave  (input  start, A, B, Bin,
                    output busy, done, Diff, Bout, Zero, Ovf);
endinterface

// File: rtl/sub16_serial.sv
// Nibble-serial 16-bit subtractor: Diff = A - B - Bin, one 4-bit slice per clock,
// LSB slice first, with the borrow chained through a register. Start/busy/done handshake.
module sub16_serial (
    input  logic           clk,
    input  logic           rst,
    sub16_serial_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [15:0] a_q, b_q, acc_q;
    logic        borrow_q;
    logic [1:0]  idx_q;
    logic        busy_q, done_q, bout_q, zero_q, ovf_q;
    logic [15:0] diff_q;

    logic [3:0]  a_sl, b_sl;
    logic [4:0]  slice;
    logic        borrow_nxt;
    logic [15:0] acc_nxt;

    // Bit 4 of the 5-bit difference goes high exactly when the slice underflows.
    always_comb begin
        a_sl       = a_q[{idx_q, 2'b00} +: 4];
        b_sl       = b_q[{idx_q, 2'b00} +: 4];
        slice      = {1'b0, a_sl} - {1'b0, b_sl} - {4'b0000, borrow_q};
        borrow_nxt = slice[4];
        acc_nxt    = acc_q;
        acc_nxt[{idx_q, 2'b00} +: 4] = slice[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q      <= bus.A;
                        b_q      <= bus.B;
                        borrow_q <= bus.Bin;
                        acc_q    <= '0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state    <= IDLE;
                    end
                end
                RUN: begin
                    acc_q    <= acc_nxt;
                    borrow_q <= borrow_nxt;
                    idx_q    <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        diff_q <= acc_nxt;
                        bout_q <= borrow_nxt;
                        zero_q <= (acc_nxt == 16'h0000);
                        ovf_q  <= (a_q[15] != b_q[15]) && (acc_nxt[15] != a_q[15]);
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Diff = diff_q;
    assign bus.Bout = bout_q;
    assign bus.Zero = zero_q;
    assign bus.Ovf  = ovf_q;
endmodule
